mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined MIPS core. It sits between the EX/MEM pipeline register and the 1024×32 word-addressed data memory, whose read is asynchronous and whose write is synchronous. It converts byte addresses and byte/half/word accesses into word accesses, and performs read-modify-write for sub-word stores using a two-cycle FSM with a stall. It also registers the MEM/WB outputs.

## Interface
Parameters:
- ADDR_W, 10, data-memory word-address width; word address = exAddr[ADDR_W+1:2].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- exValid  in  1  EX/MEM slot holds a real instruction
- exMemRead  in  1  load
- exMemWrite  in  1  store
- exSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- exSigned  in  1  sign-extend sub-word loads
- exAddr  in  32  byte address
- exStoreData  in  32  store source (sub-word data in low bits)
- exAluResult  in  32  result for non-memory instructions
- exRegWrite  in  1  instruction writes a register
- exDestReg  in  5  destination register
- dmRdEnable  out  1  to memory read enable
- dmRdAddress  out  ADDR_W  to memory read address
- dmRdData  in  32  from memory read data
- dmWrEnable  out  1  to memory write enable
- dmWrAddress  out  ADDR_W  to memory write address
- dmWrData  out  32  to memory write data
- stall  out  1  hold EX/MEM and earlier stages this cycle
- wbValid, wbRegWrite  out  1 each  MEM/WB control
- wbDestReg  out  5  MEM/WB destination
- wbData  out  32  MEM/WB result
- misalignFault  out  1  registered one-cycle pulse, aligned with wbValid

## Operation
- Byte lanes are little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
- Misaligned access: a half with addr[0]=1, or a word with addr[1:0]≠0.
  - No memory write occurs and wbRegWrite=0.
  - misalignFault=1 together with wbValid=1 at the next edge.
- Word store: in the same cycle, dmWrEnable=1, dmWrAddress=word address, dmWrData=exStoreData. No stall.
- Load:
  - dmRdEnable=1 and dmRdAddress=word address, both combinational.
  - Lane is selected from dmRdData and zero- or sign-extended per exSigned; a word load passes through.
  - The result is captured into wbData at the edge.
- Sub-word store uses FSM states IDLE and MERGE.
  - IDLE, with a valid aligned byte/half store: dmRdEnable=1 and stall=1. At the edge, the merged word (dmRdData with the lane replaced by exStoreData low bits) goes into a holding register, and the FSM moves to MERGE. MEM/WB receives a bubble (wbValid=0).
  - MERGE: dmWrEnable=1 with the holding-register word; stall=0; the FSM returns to IDLE at the edge. MEM/WB receives the store with wbValid=1 and wbRegWrite=0.
- exMemRead and exMemWrite both set: the access is treated as a store and wbRegWrite is forced to 0.
- Non-memory instruction: wbData=exAluResult, with no memory enables.
- wbRegWrite = exValid & exRegWrite & (exDestReg≠0) & ~store & ~misaligned.
- exValid=0: all memory enables are 0, no stall, and wbValid=0 at the edge.

## Timing
- Reset values:
  - state=IDLE
  - wbValid, wbRegWrite, misalignFault = 0
  - wbDestReg = 0, wbData = 0
  - holding register = 0
- While reset is high, dmWrEnable, dmRdEnable and stall are forced to 0.
- Reset asserted in MERGE: the pending write is dropped and the FSM returns to IDLE.
- Load latency: 1 cycle (EX/MEM to MEM/WB).
- Word store: 1 cycle. Sub-word store: 2 cycles with exactly one stall cycle.
- In MERGE the unit uses only the holding register and ignores ex* data. Upstream must hold its inputs during the stall cycle.
- A load to the same word immediately after a sub-word store reads the updated word, because the memory write lands at the MERGE edge.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4 KiB.
- dm* outputs are combinational from state and ex* inputs. wb* and misalignFault are registered.

## Test plan
- Reset behaviour: reset for 2 cycles → all wb* outputs 0 and stall=0. Then assert reset while in MERGE → no write; mem[5] keeps its prior value.
- Word store then load: sw 0xDEADBEEF to 0x14, then lw 0x14 → mem[5]=0xDEADBEEF; wbData=0xDEADBEEF one cycle after the load.
- Byte store with read-modify-write: mem[5]=0x11223344; sb 0xAB to 0x16 → stall high for exactly 1 cycle; mem[5]=0x11AB3344; wbValid 0 then 1.
- Sub-word loads from mem[5]=0x8000FF7F:
  - lb 0x14 → 0x0000007F
  - lb 0x15 → 0xFFFFFFFF
  - lbu 0x15 → 0x000000FF
  - lh 0x16 → 0xFFFF8000
  - lhu 0x16 → 0x00008000
- Misaligned accesses: lw 0x15 and sh 0x17 → misalignFault pulses 1 cycle each; wbRegWrite=0; memory unchanged.
- Destination and address edge cases:
  - ALU passthrough with exDestReg=0 → wbRegWrite=0.
  - sw to 0x1000 → writes mem[0] (address wrap).

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
// Turns byte/half/word loads and stores into accesses on a word-addressed data
// memory (asynchronous read, synchronous write). Sub-word stores are done as a
// read-modify-write: one stall cycle reads and merges the word, and the next
// cycle writes it. MEM/WB outputs and the misalignment fault are registered.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   ex_*_i                    EX/MEM pipeline register contents
//   dm_rd_enable_o/address_o  memory read request (combinational)
//   dm_rd_data_i              memory read data (combinational from address)
//   dm_wr_enable_o/address_o/data_o  memory write request (lands at the edge)
//   stall_o                   hold EX/MEM and earlier stages this cycle
//   wb_*_o                    MEM/WB pipeline register contents
//   misalign_fault_o          one-cycle pulse, aligned with wb_valid_o
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic [1:0]        ex_size_i,
  input  logic              ex_signed_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_store_data_i,
  input  logic [31:0]       ex_alu_result_i,
  input  logic              ex_reg_write_i,
  input  logic [4:0]        ex_dest_reg_i,
  output logic              dm_rd_enable_o,
  output logic [ADDR_W-1:0] dm_rd_address_o,
  input  logic [31:0]       dm_rd_data_i,
  output logic              dm_wr_enable_o,
  output logic [ADDR_W-1:0] dm_wr_address_o,
  output logic [31:0]       dm_wr_data_o,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic              wb_reg_write_o,
  output logic [4:0]        wb_dest_reg_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_fault_o
);

  typedef enum logic [0:0] {StIdle, StMerge} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_dest_q, wb_dest_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              fault_q, fault_d;

  logic              is_store, is_load, is_word, is_half;
  logic              misaligned, sub_store;
  logic [ADDR_W-1:0] word_addr;
  logic [4:0]        shamt;
  logic [31:0]       rd_shifted, load_data, lane_mask, store_lane, merged_data;

  // Access decode. A load with write also set is treated as a store.
  always_comb begin
    is_store   = ex_mem_write_i;
    is_load    = ex_mem_read_i & ~ex_mem_write_i;
    is_word    = ex_size_i[1];
    is_half    = (ex_size_i == 2'b01);
    misaligned = (is_store | is_load) &
                 ((is_half & ex_addr_i[0]) | (is_word & (ex_addr_i[1:0] != 2'b00)));
    sub_store  = ex_valid_i & is_store & ~is_word & ~misaligned;
    word_addr  = ex_addr_i[ADDR_W+1:2];
    shamt      = {ex_addr_i[1:0], 3'b000};
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    rd_shifted = dm_rd_data_i >> shamt;
    if (is_word) begin
      load_data = dm_rd_data_i;
    end else if (is_half) begin
      load_data = {{16{ex_signed_i & rd_shifted[15]}}, rd_shifted[15:0]};
    end else begin
      load_data = {{24{ex_signed_i & rd_shifted[7]}}, rd_shifted[7:0]};
    end
    lane_mask   = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    store_lane  = (ex_store_data_i << shamt) & lane_mask;
    merged_data = (dm_rd_data_i & ~lane_mask) | store_lane;
  end

  // FSM state register plus all pipeline registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_data_q      <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_dest_q      <= wb_dest_d;
      wb_data_q      <= wb_data_d;
      fault_q        <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (sub_store) state_d = StMerge;
      StMerge: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side outputs and stall (combinational).
  always_comb begin
    dm_rd_enable_o  = 1'b0;
    dm_rd_address_o = word_addr;
    dm_wr_enable_o  = 1'b0;
    dm_wr_address_o = word_addr;
    dm_wr_data_o    = ex_store_data_i;
    stall_o         = 1'b0;
    if (!reset_i) begin
      if (state_q == StMerge) begin
        // ex_* is ignored here; the write comes entirely from the holding regs.
        dm_wr_enable_o  = 1'b1;
        dm_wr_address_o = hold_addr_q;
        dm_wr_data_o    = hold_data_q;
      end else if (ex_valid_i && !misaligned) begin
        if (is_load) begin
          dm_rd_enable_o = 1'b1;
        end else if (is_store) begin
          if (is_word) begin
            dm_wr_enable_o = 1'b1;
          end else begin
            dm_rd_enable_o = 1'b1;
            stall_o        = 1'b1;
          end
        end
      end
    end
  end

  // Holding register and MEM/WB next values. Stores report the written word
  // on wb_data with destination 0; they never write a register.
  always_comb begin
    hold_addr_d    = hold_addr_q;
    hold_data_d    = hold_data_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_dest_d      = '0;
    wb_data_d      = '0;
    fault_d        = 1'b0;
    if (state_q == StMerge) begin
      wb_valid_d = 1'b1;
      wb_data_d  = hold_data_q;
    end else if (ex_valid_i) begin
      if (misaligned) begin
        wb_valid_d = 1'b1;
        fault_d    = 1'b1;
      end else if (is_store) begin
        if (is_word) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ex_store_data_i;
        end else begin
          // First half of the read-modify-write: MEM/WB gets a bubble.
          hold_addr_d = word_addr;
          hold_data_d = merged_data;
        end
      end else begin
        wb_valid_d     = 1'b1;
        wb_reg_write_d = ex_reg_write_i & (ex_dest_reg_i != 5'd0);
        wb_dest_d      = ex_dest_reg_i;
        wb_data_d      = is_load ? load_data : ex_alu_result_i;
      end
    end
  end

  assign wb_valid_o       = wb_valid_q;
  assign wb_reg_write_o   = wb_reg_write_q;
  assign wb_dest_reg_o    = wb_dest_q;
  assign wb_data_o        = wb_data_q;
  assign misalign_fault_o = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_signed, ex_reg_write;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_store_data, ex_alu_result;
  logic [4:0]  ex_dest_reg;
  logic        dm_rd_enable, dm_wr_enable, stall;
  logic [9:0]  dm_rd_address, dm_wr_address;
  logic [31:0] dm_rd_data, dm_wr_data;
  logic        wb_valid, wb_reg_write, misalign_fault;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(10)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .ex_valid_i       (ex_valid),
    .ex_mem_read_i    (ex_mem_read),
    .ex_mem_write_i   (ex_mem_write),
    .ex_size_i        (ex_size),
    .ex_signed_i      (ex_signed),
    .ex_addr_i        (ex_addr),
    .ex_store_data_i  (ex_store_data),
    .ex_alu_result_i  (ex_alu_result),
    .ex_reg_write_i   (ex_reg_write),
    .ex_dest_reg_i    (ex_dest_reg),
    .dm_rd_enable_o   (dm_rd_enable),
    .dm_rd_address_o  (dm_rd_address),
    .dm_rd_data_i     (dm_rd_data),
    .dm_wr_enable_o   (dm_wr_enable),
    .dm_wr_address_o  (dm_wr_address),
    .dm_wr_data_o     (dm_wr_data),
    .stall_o          (stall),
    .wb_valid_o       (wb_valid),
    .wb_reg_write_o   (wb_reg_write),
    .wb_dest_reg_o    (wb_dest_reg),
    .wb_data_o        (wb_data),
    .misalign_fault_o (misalign_fault)
  );

  // Data memory: asynchronous read, synchronous write.
  logic [31:0] ram [0:1023];
  assign dm_rd_data = ram[dm_rd_address];
  always @(posedge clk) if (dm_wr_enable) ram[dm_wr_address] <= dm_wr_data;

  // Reference memory, updated at instruction issue from the ISA rules.
  logic [31:0] ref_mem [0:1023];

  // One expected record per clock cycle.
  typedef struct {
    logic        stall, rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        valid, rw, fault, chk_data;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Compare process: combinational outputs mid-cycle, registered after the edge.
  initial begin : compare_p
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("stall", 32'(stall), 32'(e.stall));
        chk("dm_rd_enable", 32'(dm_rd_enable), 32'(e.rd_en));
        chk("dm_wr_enable", 32'(dm_wr_enable), 32'(e.wr_en));
        if (e.rd_en) chk("dm_rd_address", 32'(dm_rd_address), 32'(e.rd_addr));
        if (e.wr_en) begin
          chk("dm_wr_address", 32'(dm_wr_address), 32'(e.wr_addr));
          chk("dm_wr_data", dm_wr_data, e.wr_data);
        end
        @(posedge clk);
        #2;
        chk("wb_valid", 32'(wb_valid), 32'(e.valid));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("misalign_fault", 32'(misalign_fault), 32'(e.fault));
        if (e.chk_data) begin
          chk("wb_dest_reg", 32'(wb_dest_reg), 32'(e.dest));
          chk("wb_data", wb_data, e.data);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] alu, input logic rw, input logic [4:0] d);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_signed = sg;
    ex_addr = a; ex_store_data = sd; ex_alu_result = alu; ex_reg_write = rw; ex_dest_reg = d;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      e = blank();
      e.chk_data = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Issue one instruction; a sub-word store holds its inputs for two cycles.
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] alu, input logic rw, input logic [4:0] d);
    exp_t e;
    logic mis;
    int off;
    logic [9:0] w;
    logic [31:0] old, mask, nw, sh;
    @(negedge clk);
    reset = 1'b0;
    drive(v, rd, wr, sz, sg, a, sd, alu, rw, d);
    w   = a[11:2];
    off = int'(a[1:0]);
    old = ref_mem[w];
    mis = (rd || wr) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    e = blank();
    e.rd_addr = w;
    e.wr_addr = w;
    if (!v) begin
      e.valid = 1'b0;
    end else if (mis) begin
      e.valid = 1'b1;
      e.fault = 1'b1;
    end else if (wr && sz[1]) begin
      e.wr_en = 1'b1; e.wr_data = sd; e.valid = 1'b1;
      ref_mem[w] = sd;
    end else if (wr) begin
      mask = (sz == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
      nw = (old & ~mask) | ((sd << (8 * off)) & mask);
      e.stall = 1'b1; e.rd_en = 1'b1;
      exp_q.push_back(e);
      e = blank();
      e.wr_en = 1'b1; e.wr_addr = w; e.wr_data = nw; e.valid = 1'b1;
      ref_mem[w] = nw;
      @(negedge clk);
    end else begin
      e.valid = 1'b1; e.chk_data = 1'b1; e.dest = d; e.rw = rw && (d != 5'd0);
      if (rd) begin
        e.rd_en = 1'b1;
        sh = old >> (8 * off);
        case (sz)
          2'b00:   e.data = sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
          2'b01:   e.data = sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
          default: e.data = old;
        endcase
      end else begin
        e.data = alu;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic wait_wb();
    @(posedge clk);
    #2;
  endtask

  // Sub-word store with reset raised during its MERGE cycle.
  task automatic sub_store_reset(input logic [31:0] a, input logic [31:0] sd);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, a, sd, 32'h0, 1'b0, 5'd0);
    e = blank();
    e.stall = 1'b1; e.rd_en = 1'b1; e.rd_addr = a[11:2];
    exp_q.push_back(e);
    @(negedge clk);
    reset = 1'b1;
    e = blank();
    e.chk_data = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    ex_valid = 1'b0;
    exp_q.push_back(blank());
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    do_reset(2);
    wait_wb();
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    // sw / lw
    do_op(1, 0, 1, 2'b10, 0, 32'h14, 32'hDEAD_BEEF, 32'h0, 0, 5'd0);
    do_op(1, 1, 0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 1, 5'd3);
    wait_wb();
    chk("lw14_data", wb_data, 32'hDEAD_BEEF);
    chk("sw14_mem5", ram[5], 32'hDEAD_BEEF);

    // sb read-modify-write
    do_op(1, 0, 1, 2'b10, 0, 32'h14, 32'h1122_3344, 32'h0, 0, 5'd0);
    do_op(1, 0, 1, 2'b00, 0, 32'h16, 32'hFFFF_FFAB, 32'h0, 0, 5'd0);
    wait_wb();
    chk("sb16_mem5", ram[5], 32'h11AB_3344);
    chk("sb16_wb_valid", 32'(wb_valid), 32'd1);

    // sub-word loads
    do_op(1, 0, 1, 2'b10, 0, 32'h14, 32'h8000_FF7F, 32'h0, 0, 5'd0);
    do_op(1, 1, 0, 2'b00, 1, 32'h14, 32'h0, 32'h0, 1, 5'd4);
    wait_wb(); chk("lb14", wb_data, 32'h0000_007F);
    do_op(1, 1, 0, 2'b00, 1, 32'h15, 32'h0, 32'h0, 1, 5'd4);
    wait_wb(); chk("lb15", wb_data, 32'hFFFF_FFFF);
    do_op(1, 1, 0, 2'b00, 0, 32'h15, 32'h0, 32'h0, 1, 5'd4);
    wait_wb(); chk("lbu15", wb_data, 32'h0000_00FF);
    do_op(1, 1, 0, 2'b01, 1, 32'h16, 32'h0, 32'h0, 1, 5'd4);
    wait_wb(); chk("lh16", wb_data, 32'hFFFF_8000);
    do_op(1, 1, 0, 2'b01, 0, 32'h16, 32'h0, 32'h0, 1, 5'd4);
    wait_wb(); chk("lhu16", wb_data, 32'h0000_8000);

    // misaligned
    do_op(1, 1, 0, 2'b10, 0, 32'h15, 32'h0, 32'h0, 1, 5'd5);
    wait_wb();
    chk("lw15_fault", 32'(misalign_fault), 32'd1);
    chk("lw15_regwrite", 32'(wb_reg_write), 32'd0);
    do_op(1, 0, 1, 2'b01, 0, 32'h17, 32'h0000_1234, 32'h0, 0, 5'd0);
    wait_wb();
    chk("sh17_fault", 32'(misalign_fault), 32'd1);
    chk("sh17_mem5", ram[5], 32'h8000_FF7F);

    // ALU to r0, address wrap
    do_op(1, 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h55, 1, 5'd0);
    wait_wb(); chk("alu_r0_regwrite", 32'(wb_reg_write), 32'd0);
    do_op(1, 0, 1, 2'b10, 0, 32'h1000, 32'h0BAD_F00D, 32'h0, 0, 5'd0);
    wait_wb(); chk("sw1000_mem0", ram[0], 32'h0BAD_F00D);

    // reset while in MERGE drops the write
    do_op(1, 0, 1, 2'b10, 0, 32'h14, 32'hCAFE_F00D, 32'h0, 0, 5'd0);
    sub_store_reset(32'h15, 32'h99);
    wait_wb();
    chk("rst_merge_mem5", ram[5], 32'hCAFE_F00D);
    do_op(1, 1, 0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 1, 5'd7);

    // random phase over words 0..15
    for (int w = 0; w < 16; w++)
      do_op(1, 0, 1, 2'b10, 0, ($urandom & 32'hFFFF_F000) | (w << 2), $urandom, 32'h0, 0, 5'd0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int k;
      logic v, rd, wr;
      a = $urandom;
      a[11:6] = 6'b0;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      k = $urandom_range(0, 9);
      v = 1'b1; rd = 1'b0; wr = 1'b0;
      if (k <= 2) rd = 1'b1;
      else if (k <= 5) wr = 1'b1;
      else if (k == 6) begin rd = 1'b1; wr = 1'b1; end
      else if (k == 9) begin
        v = 1'b0; rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      end
      do_op(v, rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    idle(3);
    for (int w = 0; w < 16; w++) chk("final_mem", ram[w], ref_mem[w]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
